// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants, state encoding and helper functions.
package sm4_pkg;

    localparam int unsigned ROUNDS   = 32;
    localparam logic [4:0]  LAST_IDX = 5'(ROUNDS - 1);
    localparam logic [7:0]  CK_STEP  = 8'd28;

    localparam logic [31:0] FK0     = 32'hA3B1BAC6;
    localparam logic [31:0] FK1     = 32'h56AA3350;
    localparam logic [31:0] FK2     = 32'h677D9197;
    localparam logic [31:0] FK3     = 32'hB27022DC;
    localparam logic [31:0] CK_INIT = 32'h00070E15;

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ rotl32(b, 13) ^ rotl32(b, 23);
    endfunction

    // Each byte wraps independently; no carry crosses byte lanes.
    function automatic logic [31:0] ck_next(input logic [31:0] ck);
        return {ck[31:24] + CK_STEP, ck[23:16] + CK_STEP, ck[15:8] + CK_STEP, ck[7:0] + CK_STEP};
    endfunction

endpackage

// File: rtl/sm4_tau.sv
// SM4 nonlinear layer: one S-box lookup per byte lane of a 32-bit word.
module sm4_tau
    import sm4_pkg::*;
(
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign o_y[8*g +: 8] = sbox(i_x[8*g +: 8]);
    end

endmodule

// File: rtl/sm4_key_expansion.sv
// Iterative SM4 key schedule: expands a 128-bit master key into 32 round keys, one per clock.
module sm4_key_expansion
    import sm4_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_mk,
    output logic         o_busy,
    output logic         o_rk_valid,
    output logic [31:0]  o_rk_out,
    output logic [4:0]   o_rk_idx,
    output logic         o_done
);

    state_e      r_state;
    logic [31:0] r_k0, r_k1, r_k2, r_k3;
    logic [31:0] r_ck;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_rk_valid;
    logic [31:0] r_rk_out;
    logic [4:0]  r_rk_idx;
    logic        r_done;

    logic [31:0] w_x;
    logic [31:0] w_b;
    logic [31:0] w_knew;

    assign w_x = r_k1 ^ r_k2 ^ r_k3 ^ r_ck;

    sm4_tau u_tau (
        .i_x (w_x),
        .o_y (w_b)
    );

    assign w_knew = r_k0 ^ l_prime(w_b);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_k0       <= '0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_k3       <= '0;
            r_ck       <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_out   <= '0;
            r_rk_idx   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_k0    <= i_mk[127:96] ^ FK0;
                        r_k1    <= i_mk[95:64]  ^ FK1;
                        r_k2    <= i_mk[63:32]  ^ FK2;
                        r_k3    <= i_mk[31:0]   ^ FK3;
                        r_ck    <= CK_INIT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_k0       <= r_k1;
                    r_k1       <= r_k2;
                    r_k2       <= r_k3;
                    r_k3       <= w_knew;
                    r_rk_out   <= w_knew;
                    r_rk_idx   <= r_cnt;
                    r_rk_valid <= 1'b1;
                    r_ck       <= ck_next(r_ck);
                    r_cnt      <= r_cnt + 5'd1;
                    if (r_cnt == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_rk_valid = r_rk_valid;
    assign o_rk_out   = r_rk_out;
    assign o_rk_idx   = r_rk_idx;
    assign o_done     = r_done;

endmodule

// File: tb/tb_sm4_key_expansion.sv
// Self-checking bench for sm4_key_expansion: directed vectors, a reference model and timing checks.
module tb_sm4_key_expansion;

    localparam logic [127:0] STD_MK = 128'h0123456789ABCDEFFEDCBA9876543210;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] rk;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] mk;
    logic         busy;
    logic         rk_valid;
    logic [31:0]  rk_out;
    logic [4:0]   rk_idx;
    logic         done;

    logic [31:0]  ref_rk [32];
    logic [31:0]  cap_rk [32];
    int           n_pass;
    int           n_total;

    sm4_key_expansion dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_mk       (mk),
        .o_busy     (busy),
        .o_rk_valid (rk_valid),
        .o_rk_out   (rk_out),
        .o_rk_idx   (rk_idx),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] tb_rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // CK bytes from the closed form (4i+j)*7 mod 256, MSB lane is j=0.
    function automatic logic [31:0] ck_ref(input int i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return r;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] k [36];
        logic [31:0] x, b;
        k[0] = key[127:96] ^ 32'hA3B1BAC6;
        k[1] = key[95:64]  ^ 32'h56AA3350;
        k[2] = key[63:32]  ^ 32'h677D9197;
        k[3] = key[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_ref(i);
            for (int j = 0; j < 4; j++) b[8*j +: 8] = TB_SBOX[x[8*j +: 8]];
            k[i+4] = k[i] ^ b ^ tb_rotl(b, 13) ^ tb_rotl(b, 23);
            ref_rk[i] = k[i+4];
        end
    endtask

    // Starts an expansion and checks every cycle: control outputs, rk values and optionally
    // the internal CK register. Burst b occupies cycles 33*b .. 33*b+32 after the first accept.
    task automatic run_check(input logic [127:0] key, input int nburst, input int poke_at,
                             input bit chk_ck);
        int b, jp;
        bit in_b, e_busy, e_valid, e_done;
        logic [4:0] e_idx, a_idx;
        model_expand(key);
        for (int i = 0; i < 32; i++) cap_rk[i] = '0;
        start = 1'b1;
        mk    = key;
        @(negedge clk);
        for (int j = 0; j <= 33 * nburst + 1; j++) begin
            b       = j / 33;
            jp      = j - 33 * b;
            in_b    = b < nburst;
            e_busy  = in_b && jp <= 31;
            e_valid = in_b && jp >= 1;
            e_done  = in_b && jp == 32;
            e_idx   = e_valid ? 5'(jp - 1) : 5'd0;
            a_idx   = rk_valid ? rk_idx : 5'd0;
            chk($sformatf("ctrl[%0d]", j), {busy, rk_valid, done, a_idx},
                {e_busy, e_valid, e_done, e_idx});
            if (e_valid) begin
                chk($sformatf("rk[%0d]", jp - 1), rk_out, ref_rk[jp-1]);
                cap_rk[jp-1] = rk_out;
            end
            if (chk_ck && in_b && jp <= 31) chk($sformatf("ck[%0d]", jp), dut.r_ck, ck_ref(jp));
            if (nburst == 1 && j == 0) start = 1'b0;
            if (nburst == 2 && j == 64) start = 1'b0;
            if (j == poke_at) begin
                start = 1'b1;
                mk    = '0;
            end else if (j == poke_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t tbl [5];
        tbl[0] = '{"std_rk0",  0,  32'hF12186F9};
        tbl[1] = '{"std_rk1",  1,  32'h41662B61};
        tbl[2] = '{"std_rk2",  2,  32'h5A6AB19A};
        tbl[3] = '{"std_rk3",  3,  32'h7BA92077};
        tbl[4] = '{"std_rk31", 31, 32'h9124A012};

        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        mk      = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, rk_valid, rk_out, rk_idx, done}, '0);
        chk("reset_ck", dut.r_ck, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {busy, rk_valid, done}, 3'b000);

        // Standard key, then hand-computed vectors.
        run_check(STD_MK, 1, -10, 1'b0);
        for (int i = 0; i < 5; i++) chk(tbl[i].name, cap_rk[tbl[i].idx], tbl[i].rk);

        // start with mk=0 asserted mid-run must be ignored.
        run_check(STD_MK, 1, 10, 1'b0);
        chk("ignore_rk31", cap_rk[31], 32'h9124A012);
        repeat (3) begin
            @(negedge clk);
            chk("ignore_no_second", {busy, rk_valid, done}, 3'b000);
        end

        // start held high through two expansions.
        run_check(STD_MK, 2, -10, 1'b0);
        chk("b2b_rk0", cap_rk[0], 32'hF12186F9);
        chk("b2b_rk31", cap_rk[31], 32'h9124A012);

        // Reset at round 15, together with start: reset wins, no done.
        start = 1'b1;
        mk    = STD_MK;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        chk("pre_rst_idx", {rk_valid, rk_idx}, {1'b1, 5'd15});
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {busy, rk_valid, rk_out, rk_idx, done}, '0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", {busy, rk_valid, done}, 3'b000);
        end
        run_check(STD_MK, 1, -10, 1'b0);
        chk("after_rst_rk0", cap_rk[0], 32'hF12186F9);

        // Zero key with internal CK tracking.
        run_check(128'h0, 1, -10, 1'b1);
        chk("ck_hand_r1", ck_ref(1), 32'h1C232A31);
        chk("ck_hand_r31", ck_ref(31), 32'h646B7279);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sm4_key_expansion.md
Name: sm4_key_expansion

Overview:
- Iterative SM4 key-schedule engine that expands a 128-bit master key MK into the 32 round keys rk0..rk31.
- Produces one round key per clock.
- Sits directly downstream of the byte S-box: the tau (nonlinear) layer consists of four S_box instances fed by the round XOR, and their output goes into the key-schedule linear transform L'.
- Round keys are streamed to the cipher datapath / round-key store.

Parameters:
- ROUNDS, 32, number of round keys produced; fixed by SM4, not to be overridden.
- CK_STEP, 8'd28, per-round increment of each CK byte, equal to (4*7) mod 256.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request expansion of mk; sampled only when idle
- mk  input  128  master key, MK0 in [127:96] … MK3 in [31:0]; sampled on the accepting edge only
- busy  output  1  high from the accepting edge until after the final round edge
- rk_valid  output  1  rk_out/rk_idx carry a new round key this cycle
- rk_out  output  32  round key rk_i
- rk_idx  output  5  index i of rk_out
- done  output  1  one-cycle pulse coincident with rk_idx=31

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE; all K regs=0; ck=0; cnt=0; busy=0; rk_valid=0; rk_out=0; rk_idx=0; done=0.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 (edge E0):
  - K0..K3 <= MK0..MK3 XOR FK0..FK3, where FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - ck <= 32'h00070E15; cnt <= 0; busy <= 1; go to RUN.
- IDLE, start=0: hold.
- RUN, each edge:
  - x = K1^K2^K3^ck.
  - b = tau(x), i.e. S_box applied to each byte.
  - t = b ^ rotl(b,13) ^ rotl(b,23).
  - knew = K0 ^ t.
  - Shift (K0,K1,K2,K3) <= (K1,K2,K3,knew).
  - rk_out <= knew; rk_idx <= cnt; rk_valid <= 1.
  - ck <= each byte + CK_STEP, mod 256 per byte with no carry between bytes.
  - cnt <= cnt+1.
- RUN, when cnt==31: also done <= 1, busy <= 0, next state IDLE.
- rk_valid and done are registered and deassert on the next edge unless re-set.
- Latency: rk_i appears in the cycle after edge E(i+1). Total is 32 consecutive rk_valid cycles with no gaps; there is no backpressure.
- start during RUN is ignored; mk changes during RUN have no effect.
- start on the edge right after the done cycle (state already IDLE) is accepted, so back-to-back expansions are possible with a 1-cycle gap in rk_valid.
- rst mid-RUN: return to reset values on that edge; no done is emitted and the partial sequence is abandoned.
- rst and start on the same edge: reset wins.
- All arithmetic is 32-bit XOR/rotate. CK bytes follow ck_{i,j} = (4i+j)*7 mod 256, so CK_31 = 646B7279.

Decomposition:
- Package sm4_pkg:
  - FK0..FK3 and CK_INIT (00070E15) constants.
  - ROUNDS.
  - Function rotl32(x,n).
  - Function l_prime(b) (key-schedule L').
  - Function ck_next(ck) (bytewise +28).
- Sub-module sm4_tau: 32-bit in/out, four S_box instances on bytes [31:24],[23:16],[15:8],[7:0].
- Top level holds the FSM, K shift registers, ck and cnt.

Test Plan:
- Standard vector:
  - Stimulus: mk=0123456789ABCDEFFEDCBA9876543210, pulse start.
  - Required: rk0=F12186F9, rk1=41662B61, rk2=5A6AB19A, rk3=7BA92077, rk31=9124A012.
  - Required: exactly 32 rk_valid cycles with rk_idx 0..31; done only with idx 31.
- Timing:
  - Stimulus: start accepted at E0.
  - Required: first rk_valid in the cycle after E1; busy high for 32 cycles then 0; rk_valid=0 before and after the burst.
- Ignore-while-busy:
  - Stimulus: re-assert start with mk=0 at round 10.
  - Required: sequence unchanged (rk31 still 9124A012); no second burst.
- Back-to-back:
  - Stimulus: hold start=1 continuously across two expansions of the standard key.
  - Required: second burst starts exactly 1 idle cycle after done and is identical to the first.
- Reset mid-operation:
  - Stimulus: assert rst at round 15.
  - Required: next cycle all outputs 0; no done; a fresh start then reproduces rk0=F12186F9.
- CK generator check:
  - Stimulus: run with mk=0.
  - Required: internal ck equals 00070E15 at round 0, 1C232A31 at round 1, 646B7279 at round 31; bench compares all 32 rk against a software reference model.
